// File: rtl/recursion_scheduler.sv
// recursion_scheduler
//   Sequences the forward/backward recursion over n steps. For each step t it
//   launches both engines, waits until each has reported completion, then
//   commits the alpha slice (address t) followed by the beta slice (address n-t).
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, strand     run request and received strand (captured on accept)
//   strand_q          captured strand, stable for the whole run
//   fwd_start/bwd_start, fwd_t/bwd_t   engine launch pulses and step indices
//   fwd_done/bwd_done engine completion pulses (honoured only while waiting)
//   wr_en/wr_sel/wr_t result-store write strobe, slice select, address
//   busy/done/error   run in progress / completion pulse / timeout flag
//
// Optional feature: define RECURSION_TIMEOUT_EN to bound each wait to TIMEOUT
// cycles; on expiry the scheduler parks in an error state until restarted.
module recursion_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 16,
  parameter int n          = 10,
  parameter int TIMEOUT    = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DATA_WIDTH-1:0]    strand,
  output logic [DATA_WIDTH-1:0]    strand_q,
  output logic                     fwd_start,
  output logic                     bwd_start,
  output logic [$clog2(n+1)-1:0]   fwd_t,
  output logic [$clog2(n+1)-1:0]   bwd_t,
  input  logic                     fwd_done,
  input  logic                     bwd_done,
  output logic                     wr_en,
  output logic                     wr_sel,
  output logic [$clog2(n+1)-1:0]   wr_t,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam int TW = $clog2(n+1);
  localparam logic [TW-1:0] T_N    = TW'(n);
  localparam logic [TW-1:0] T_LAST = TW'(n-1);

  if (n < 1 || N < 1 || TIMEOUT < 1) begin : g_bad_params
    $error("recursion_scheduler: n, N and TIMEOUT must all be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_COMMIT_A,
    S_COMMIT_B,
    S_FINISH,
    S_ERROR
  } state_t;

  state_t        state, state_nx;
  logic [TW-1:0] t;
  logic          f_seen, b_seen;
  logic          both_done;
  logic          in_step;

  // A done arriving in the same cycle as the other flag already counts.
  assign both_done = (f_seen | fwd_done) & (b_seen | bwd_done);

`ifdef RECURSION_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT+1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT-1);
  logic [CW-1:0] wait_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      t        <= '0;
      f_seen   <= 1'b0;
      b_seen   <= 1'b0;
      strand_q <= '0;
`ifdef RECURSION_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE, S_ERROR: begin
          if (start) begin
            strand_q <= strand;
            t        <= '0;
          end
        end
        S_LAUNCH: begin
          f_seen <= 1'b0;
          b_seen <= 1'b0;
`ifdef RECURSION_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (fwd_done) f_seen <= 1'b1;
          if (bwd_done) b_seen <= 1'b1;
`ifdef RECURSION_TIMEOUT_EN
          wait_cnt <= wait_cnt + 1'b1;
`endif
        end
        S_COMMIT_B: begin
          if (t != T_LAST) t <= t + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_ERROR: if (start) state_nx = S_LAUNCH;
      S_LAUNCH:        state_nx = S_WAIT;
      S_WAIT: begin
        if (both_done) state_nx = S_COMMIT_A;
`ifdef RECURSION_TIMEOUT_EN
        else if (wait_cnt == CNT_LAST) state_nx = S_ERROR;
`endif
      end
      S_COMMIT_A:      state_nx = S_COMMIT_B;
      S_COMMIT_B:      state_nx = (t == T_LAST) ? S_FINISH : S_LAUNCH;
      S_FINISH:        state_nx = S_IDLE;
      default:         state_nx = S_IDLE;
    endcase
  end

  // Step indices are only meaningful inside a step; elsewhere they read 0.
  assign in_step = (state == S_LAUNCH) || (state == S_WAIT) ||
                   (state == S_COMMIT_A) || (state == S_COMMIT_B);

  always_comb begin
    fwd_start = 1'b0;
    bwd_start = 1'b0;
    wr_en     = 1'b0;
    wr_sel    = 1'b0;
    wr_t      = '0;
    fwd_t     = '0;
    bwd_t     = '0;
    if (in_step) begin
      fwd_t = t;
      bwd_t = T_N - t;
    end
    case (state)
      S_LAUNCH: begin
        fwd_start = 1'b1;
        bwd_start = 1'b1;
      end
      S_COMMIT_A: begin
        wr_en = 1'b1;
        wr_t  = t;
      end
      S_COMMIT_B: begin
        wr_en  = 1'b1;
        wr_sel = 1'b1;
        wr_t   = T_N - t;
      end
      default: ;
    endcase
  end

  assign busy = in_step;
  assign done = (state == S_FINISH);
`ifdef RECURSION_TIMEOUT_EN
  assign error = (state == S_ERROR);
`else
  assign error = 1'b0;
`endif

endmodule
